// File: rtl/onehot_enc_sync.sv
// onehot_enc_sync
// Synchronises an asynchronous 8-bit one-hot bus and debounces it. Each newly settled value
// is encoded to a 3-bit index, with priority given to the MSB. The result is presented on a
// valid/ready handshake together with a flag that marks values which were not exactly one-hot.
module onehot_enc_sync #(
  parameter int STABLE_CNT = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in_code,
  input  logic       out_ready,
  output logic [2:0] out_code,
  output logic       out_err,
  output logic       out_valid,
  output logic       busy
);

  // cnt holds 0..STABLE_CNT-1. The extra bit guarantees it never wraps, even at powers of two.
  localparam int CW = $clog2(STABLE_CNT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_FILTER = 2'd1,
    S_OUT    = 2'd2
  } state_t;

  state_t          state_reg;
  logic [7:0]      sync1_reg;
  logic [7:0]      sync2_reg;
  logic [7:0]      last_reg;
  logic [7:0]      sample_reg;
  logic [CW-1:0]   cnt_reg;

  logic [7:0]      top_bit;
  logic [2:0]      enc_code;
  logic            enc_onehot;
  logic            enc_err;

  // Two-flop synchroniser. The idle value is the one-hot code for index 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_reg <= 8'h01;
      sync2_reg <= 8'h01;
    end else begin
      sync1_reg <= in_code;
      sync2_reg <= sync1_reg;
    end
  end

  // top_bit marks the highest set bit of the sample. An all-zero sample leaves it empty,
  // so the encoded index falls to 0.
  genvar gi, gj;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_top
      assign top_bit[gi] = sample_reg[gi] && ((sample_reg >> (gi + 1)) == 8'h00);
    end
    for (gi = 0; gi < 3; gi++) begin : g_code
      logic [7:0] sel;
      for (gj = 0; gj < 8; gj++) begin : g_sel
        localparam bit HIT = ((gj >> gi) % 2) == 1;
        assign sel[gj] = top_bit[gj] & HIT;
      end
      assign enc_code[gi] = |sel;
    end
  endgenerate

  // Exactly one bit is set when the value is nonzero and clearing its lowest set bit leaves zero.
  assign enc_onehot = (sample_reg != 8'h00) && ((sample_reg & (sample_reg - 8'd1)) == 8'h00);
  assign enc_err    = !enc_onehot;

  assign busy = (state_reg != S_WAIT);

  // Filter FSM: a new value must match the sample for STABLE_CNT cycles before it is encoded.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg  <= S_WAIT;
      last_reg   <= 8'h01;
      sample_reg <= 8'h01;
      cnt_reg    <= '0;
      out_code   <= 3'd0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state_reg)
        S_WAIT: begin
          if (sync2_reg != last_reg) begin
            sample_reg <= sync2_reg;
            cnt_reg    <= '0;
            state_reg  <= S_FILTER;
          end
        end
        S_FILTER: begin
          if (sync2_reg == last_reg) begin
            // The glitch fell back to the value that was already reported.
            state_reg <= S_WAIT;
          end else if (sync2_reg != sample_reg) begin
            sample_reg <= sync2_reg;
            cnt_reg    <= '0;
          end else if (cnt_reg != CNT_LAST) begin
            cnt_reg <= cnt_reg + CW'(1);
          end else begin
            out_code  <= enc_code;
            out_err   <= enc_err;
            out_valid <= 1'b1;
            last_reg  <= sample_reg;
            state_reg <= S_OUT;
          end
        end
        S_OUT: begin
          // Input is ignored here. A change is picked up again from S_WAIT because it differs from last.
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= S_WAIT;
          end
        end
        default: begin
          state_reg <= S_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_enc_sync.sv
// tb_onehot_enc_sync
// A scoreboard-driven bench. When a settled input is driven, its expected {err, code} is pushed
// onto a queue. A negedge monitor pops one entry on every accepted result and compares it.
module tb_onehot_enc_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_code;
  logic       out_ready;
  logic [2:0] out_code;
  logic       out_err;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  onehot_enc_sync #(.STABLE_CNT(4)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .in_code   (in_code),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_err   (out_err),
    .out_valid (out_valid),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Model encoder: the highest set bit gives the index, and the flag is set unless exactly one bit is set.
  function automatic logic [3:0] model(input logic [7:0] v);
    logic [2:0] c;
    int n;
    c = 3'd0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        c = 3'(i);
        n++;
      end
    end
    return {(n != 1), c};
  endfunction

  // An accepted transfer happens at the next rising edge. It is sampled here, half a cycle early.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {28'd0, out_err, out_code}, 32'hFFFF_FFFF);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        $display("txn code=%0d err=%0d (want code=%0d err=%0d)", out_code, out_err, e[2:0], e[3]);
        check("result", {28'd0, out_err, out_code}, {28'd0, e});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_code = 8'h01;
    exp_q.delete();
    step(3);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic drive(input logic [7:0] v, input bit expect_out);
    in_code = v;
    if (expect_out) exp_q.push_back(model(v));
  endtask

  task automatic wait_empty(input string tag, input int maxc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    step(2);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int n;
    n = 0;
    while (!out_valid && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, out_valid, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_code = 8'h01;
    out_ready = 1'b1;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_code", out_code, 0);
    check("rst_err", out_err, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // 1: idle with the reset value. The monitor flags any output that appears.
    step(20);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);

    // 2: exact latency. The change lands before edge k and valid is expected right after edge k+6.
    drive(8'h20, 1);
    step(6);
    check("lat_not_yet", out_valid, 0);
    step(1);
    check("lat_valid", out_valid, 1);
    check("lat_code", out_code, 5);
    check("lat_err", out_err, 0);
    step(1);
    check("lat_drop", out_valid, 0);
    wait_empty("t2_drain", 20);

    // 3: a short glitch produces nothing. A restarted filter reports only the final value.
    do_reset();
    drive(8'h08, 0);
    step(2);
    drive(8'h01, 0);
    step(1);
    check("glitch_busy", busy, 1);
    step(10);
    check("glitch_idle", busy, 0);
    drive(8'h08, 0);
    step(3);
    drive(8'h10, 1);
    wait_empty("t3_drain", 30);
    check("t3_idle", busy, 0);

    // 4: values that are not one-hot, both all-zero and multi-bit.
    drive(8'h00, 1);
    wait_empty("t4a_drain", 30);
    drive(8'h48, 1);
    wait_empty("t4b_drain", 30);

    // 5: backpressure. The result stays frozen while the input changes underneath it.
    do_reset();
    out_ready = 1'b0;
    drive(8'h02, 1);
    wait_valid("bp_valid", 20);
    step(1);
    drive(8'h80, 1);
    step(10);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_code", out_code, 1);
    check("bp_hold_busy", busy, 1);
    out_ready = 1'b1;
    step(2);
    check("bp_refilter", busy, 1);
    wait_empty("t5_drain", 30);

    // 6: an asynchronous reset while in S_FILTER, and another while in S_OUT.
    do_reset();
    drive(8'h20, 0);
    step(4);
    check("f_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    in_code = 8'h01;
    #1;
    check("f_rst_busy", busy, 0);
    check("f_rst_valid", out_valid, 0);
    step(2);
    rst_n = 1'b1;
    step(20);
    check("f_after_busy", busy, 0);

    out_ready = 1'b0;
    drive(8'h04, 0);
    wait_valid("o_valid_pre", 20);
    #2;
    rst_n = 1'b0;
    in_code = 8'h01;
    #1;
    check("o_rst_valid", out_valid, 0);
    check("o_rst_code", out_code, 0);
    check("o_rst_busy", busy, 0);
    step(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step(20);
    check("o_after_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
